// File: rtl/mavg_pkg.sv
// Shared types and sizing helpers for the moving-average window controller.
package mavg_pkg;

  typedef enum logic {
    FILL,
    RUN
  } state_t;

  // Default window length; the top derives WIN_LOG2 from it unless overridden.
  localparam int unsigned N = 16;

  function automatic int unsigned sum_w(input int unsigned data_width,
                                        input int unsigned win_log2);
    return data_width + win_log2;
  endfunction

endpackage

// File: rtl/mavg_div_round.sv
// Window-sum to average divider; `MAVG_ROUND_EN selects round-half-up with saturation,
// otherwise the average is a plain truncating shift.
module mavg_div_round #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WIN_LOG2   = 4,
  parameter int unsigned SUM_W      = 12
) (
  input  logic [SUM_W-1:0]      sum,
  output logic [DATA_WIDTH-1:0] avg
);

`ifdef MAVG_ROUND_EN
  localparam logic [SUM_W:0] HALF = (SUM_W+1)'(1) << (WIN_LOG2 - 1);
  localparam logic [SUM_W:0] MAX  = (SUM_W+1)'((1 << DATA_WIDTH) - 1);

  logic [SUM_W:0] rnd;
  logic [SUM_W:0] quo;

  // One extra bit so the rounding addend can never wrap.
  assign rnd = {1'b0, sum} + HALF;
  assign quo = rnd >> WIN_LOG2;
  assign avg = (quo > MAX) ? '1 : quo[DATA_WIDTH-1:0];
`else
  assign avg = DATA_WIDTH'(sum >> WIN_LOG2);
`endif

endmodule

// File: rtl/mavg_window_ctrl.sv
// Boxcar moving-average controller wrapped around an external FWFT FIFO delay line.
// Build option: `MAVG_ROUND_EN (rounded, saturating average; default truncates).
module mavg_window_ctrl
  import mavg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WIN_LOG2   = $clog2(N),
  parameter int unsigned FIFO_AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] fifo_din,
  output logic                  fifo_wr_en,
  input  logic                  fifo_full,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  input  logic                  fifo_empty,
  output logic                  fifo_rst,
  output logic                  err
);

  localparam int unsigned SUM_W = sum_w(DATA_WIDTH, WIN_LOG2);
  localparam int unsigned WIN_N = 1 << WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = WIN_LOG2'(WIN_N - 1);

  if (WIN_LOG2 < 1) begin : g_bad_win
    $error("mavg_window_ctrl: WIN_LOG2 must be >= 1");
  end
  if (FIFO_AW < WIN_LOG2 + 1) begin : g_bad_fifo
    $error("mavg_window_ctrl: FIFO_AW must be >= WIN_LOG2+1");
  end

  state_t                state;
  state_t                state_nx;
  logic [WIN_LOG2-1:0]   cnt;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      sum_nx;
  logic [DATA_WIDTH-1:0] oldest;
  logic [DATA_WIDTH-1:0] avg_nx;
  logic                  clr_q;
  logic                  acc;
  logic                  load_out;

  assign in_ready   = ~clr & ~clr_q & (~out_valid | out_ready) & ~fifo_full;
  assign acc        = in_valid & in_ready;
  assign fifo_din   = in_data;
  assign fifo_wr_en = acc;
  assign fifo_rd_en = acc & (state == RUN);
  assign fifo_rst   = ~rst_n | clr_q;

  // An empty FIFO in RUN is a fault; substituting zero keeps the datapath defined.
  assign oldest = fifo_empty ? '0 : fifo_dout;
  assign sum_nx = (state == RUN) ? sum + SUM_W'(in_data) - SUM_W'(oldest)
                                 : sum + SUM_W'(in_data);

  // The N-th fill sample produces the first average, same as every RUN accept.
  assign load_out = acc & ((state == RUN) | (cnt == CNT_LAST));

  mavg_div_round #(
    .DATA_WIDTH (DATA_WIDTH),
    .WIN_LOG2   (WIN_LOG2),
    .SUM_W      (SUM_W)
  ) u_div (
    .sum (sum_nx),
    .avg (avg_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (clr) begin
      state_nx = FILL;
    end else if (acc && state == FILL && cnt == CNT_LAST) begin
      state_nx = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sum       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      clr_q <= clr;
      if (fifo_rd_en && fifo_empty) begin
        err <= 1'b1;
      end
      if (clr) begin
        cnt       <= '0;
        sum       <= '0;
        out_valid <= 1'b0;
      end else begin
        if (acc) begin
          sum <= sum_nx;
          if (state == FILL) begin
            cnt <= cnt + WIN_LOG2'(1);
          end
        end
        if (load_out) begin
          out_data  <= avg_nx;
          out_valid <= 1'b1;
        end else if (out_ready && out_valid) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule
